pkt_tx_pacer: RTL
=================

PKT_TX_PACER -- requirements
Module: pkt_tx_pacer

Interface
REQ-001 Parameter DWIDTH, 32, scheduler descriptor width.
REQ-002 Parameter LEN_W, 12, length field width, descriptor bits [LEN_W-1:0].
REQ-003 Parameter TOK_W, 16, token bucket width (bytes).
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-006 sch_valid  in  1  scheduler output holds a descriptor (show-ahead).
REQ-007 sch_data  in  DWIDTH  descriptor: [DWIDTH-1:LEN_W] buffer address, [LEN_W-1:0] length.
REQ-008 sch_deque_en  out  1  one-cycle pop to scheduler output FIFO.
REQ-009 cfg_pace_en  in  1  1 = token pacing active; 0 = bypass tokens.
REQ-010 cfg_rate  in  8  bytes credited per cycle.
REQ-011 cfg_burst  in  TOK_W  bucket ceiling.
REQ-012 tx_valid  out  1  egress descriptor valid.
REQ-013 tx_ready  in  1  egress accepts when tx_valid&&tx_ready.
REQ-014 tx_addr  out  DWIDTH-LEN_W  buffer address of current packet.
REQ-015 tx_len  out  LEN_W  packet length.
REQ-016 tokens  out  TOK_W  current bucket level.

Function
REQ-017 FSM states IDLE, FETCH, WAIT_TOK, SEND (enum in package).
REQ-018 IDLE: sch_valid=1 -> sch_deque_en=1 same cycle, capture sch_data into addr/len regs, next FETCH; else stay.
REQ-019 FETCH: one cycle; next WAIT_TOK; sch_deque_en=0.
REQ-020 WAIT_TOK: go SEND when cfg_pace_en=0, or tokens>=len, or (len>cfg_burst and tokens==cfg_burst).
REQ-021 SEND: tx_valid=1, tx_addr/tx_len stable until tx_valid&&tx_ready; on accept next IDLE.
REQ-022 Min latency sch_valid rise -> tx_valid = 2 cycles (IDLE, FETCH); throughput one packet per 3 cycles max.
REQ-023 Each cycle tokens_next = min(tokens + cfg_rate - debit, cfg_burst), debit applied in accept cycle only.
REQ-024 Debit = len, or full bucket (result 0) when len>tokens under the oversize rule; never underflow.
REQ-025 Addition at TOK_W+1 bits, saturated to cfg_burst; cfg_rate zero-extended.
REQ-026 cfg_pace_en=0: no debit, credit still accrues to cfg_burst.
REQ-027 len=0: needs 0 tokens, debit 0, still sent.
REQ-028 cfg_burst lowered below tokens: tokens clamp to cfg_burst next cycle.
REQ-029 sch_valid falling while in FETCH/WAIT_TOK/SEND: no effect; captured descriptor retained.
REQ-030 sch_deque_en asserted only in IDLE with sch_valid=1, never two consecutive cycles.

Reset
REQ-031 rst=0 asynchronously: state IDLE, tokens 0, sch_deque_en 0, tx_valid 0, tx_addr 0, tx_len 0.
REQ-032 Reset mid-SEND drops in-flight descriptor; no tx_valid until new capture after release.
REQ-033 Release synchronous to clk; first credit on first clk edge after release.

Configuration
REQ-034 Macro PKT_TX_PACER_STATS_EN defined: outputs stat_pkts (32b) and stat_bytes (48b) increment on each tx accept (by 1 and tx_len), wrap modulo width, reset to 0.
REQ-035 Macro undefined: stat ports and counters absent; all other behaviour identical.

Structure
REQ-036 Package pkt_tx_pacer_pkg: FSM state enum, descriptor field helpers/LEN_W default constant.
REQ-037 Sub-module tok_bucket (credit/debit/saturate, tokens register); FSM and capture regs in top.

Verification
REQ-038 Reset release, cfg_rate=4, cfg_burst=100, no traffic -> tokens 0,4,8..,100 then holds 100.
REQ-039 Tokens=100, descriptor len=64, tx_ready=1 -> tx_valid 2 cycles after sch_valid, tokens in accept cycle -> 100-64+4=40.
REQ-040 Tokens=0, rate=8, len=40 -> tx_valid asserts when tokens>=40 (5th credit), tokens after accept=8.
REQ-041 cfg_burst=50, len=200 -> sent when tokens==50, tokens after accept = rate (0 + credit).
REQ-042 tx_ready held 0 for 10 cycles in SEND -> tx_addr/tx_len stable, no new sch_deque_en, tokens keep accruing.
REQ-043 rst=0 mid-SEND -> tx_valid drops immediately, tokens 0; with STATS_EN stat_pkts=0.

Source files
------------

// File: rtl/pkt_tx_pacer_pkg.sv
// pkt_tx_pacer_pkg
//   Shared definitions for the packet transmit pacer:
//   - default widths for the descriptor, length field and token bucket
//   - the pacer FSM state type
//   - descriptor field helpers for the default 32-bit descriptor layout
//     ([31:LEN_W] buffer address, [LEN_W-1:0] length)
//   Optional statistics counters in the top level are enabled by defining
//   the macro PKT_TX_PACER_STATS_EN.
package pkt_tx_pacer_pkg;

    localparam int unsigned DWIDTH_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 12;
    localparam int unsigned TOK_W_DEF  = 16;

    // StFetch and StWaitTok both evaluate the token check; StFetch is the
    // single bookkeeping cycle after the pop, StWaitTok is where a packet
    // parks while the bucket refills.
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWaitTok,
        StSend
    } pacer_state_e;

    // Length field of a default-width descriptor.
    function automatic logic [LEN_W_DEF-1:0] desc_len(input logic [DWIDTH_DEF-1:0] desc);
        return desc[LEN_W_DEF-1:0];
    endfunction

    // Buffer address field of a default-width descriptor.
    function automatic logic [DWIDTH_DEF-LEN_W_DEF-1:0] desc_addr(
        input logic [DWIDTH_DEF-1:0] desc
    );
        return desc[DWIDTH_DEF-1:LEN_W_DEF];
    endfunction

endpackage

// File: rtl/pkt_tx_pacer_tok_bucket.sv
// tok_bucket
//   Byte-credit token bucket for the transmit pacer.
//   Every cycle the bucket gains 'rate' bytes, loses the debit of an accepted
//   packet (if any), and is clamped to the 'burst' ceiling.
//
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous reset, active low; bucket empties
//   rate       in   bytes credited per cycle (zero-extended)
//   burst      in   bucket ceiling
//   debit_en   in   an accepted packet is charged this cycle
//   debit_len  in   length of the accepted packet
//   tokens     out  current bucket level (registered)
//   tokens_nxt out  level the bucket will hold after this clock edge
module tok_bucket
    import pkt_tx_pacer_pkg::*;
#(
    parameter int unsigned TOK_W = TOK_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rate,
    input  logic [TOK_W-1:0] burst,
    input  logic             debit_en,
    input  logic [LEN_W-1:0] debit_len,
    output logic [TOK_W-1:0] tokens,
    output logic [TOK_W-1:0] tokens_nxt
);

    // One extra bit so the credit addition can never wrap before the clamp.
    localparam int unsigned SW = TOK_W + 1;
    // Common width for comparing a length against a bucket level.
    localparam int unsigned CW = (TOK_W > LEN_W) ? TOK_W : LEN_W;

    logic [CW-1:0]    len_x;
    logic [CW-1:0]    tok_x;
    logic [TOK_W-1:0] debit;
    logic [SW-1:0]    sum;

    always_comb begin
        len_x = CW'(debit_len);
        tok_x = CW'(tokens);
        debit = '0;
        // A packet longer than the bucket (oversize rule, or a ceiling that
        // was lowered after the decision) takes whatever is there, so the
        // subtraction below can never go negative.
        if (debit_en) begin
            debit = (len_x > tok_x) ? tokens : TOK_W'(debit_len);
        end
        sum        = {1'b0, tokens} + SW'(rate) - {1'b0, debit};
        tokens_nxt = (sum > {1'b0, burst}) ? burst : sum[TOK_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tokens <= '0;
        end else begin
            tokens <= tokens_nxt;
        end
    end

endmodule

// File: rtl/pkt_tx_pacer.sv
// pkt_tx_pacer
//   Pops descriptors from a show-ahead scheduler FIFO and releases them to
//   the egress port at a rate limited by a byte token bucket.
//
//   Flow per packet: IDLE (pop + capture) -> FETCH -> [WAIT_TOK] -> SEND.
//   The token check is made against the level the bucket will hold on the
//   next cycle, so a packet enters SEND exactly when the bucket covers it and
//   an already-covered packet skips WAIT_TOK entirely (2-cycle latency,
//   one packet per 3 cycles at best).
//
// Ports
//   clk           in   clock, all state on posedge
//   rst           in   asynchronous reset, active low
//   sch_valid     in   scheduler FIFO head holds a descriptor
//   sch_data      in   descriptor {buffer address, length}
//   sch_deque_en  out  one-cycle pop of the scheduler FIFO
//   cfg_pace_en   in   1 = token pacing active, 0 = send without tokens
//   cfg_rate      in   bytes credited per cycle
//   cfg_burst     in   bucket ceiling
//   tx_valid      out  egress descriptor valid
//   tx_ready      in   egress accepts when tx_valid && tx_ready
//   tx_addr       out  buffer address of current packet
//   tx_len        out  length of current packet
//   tokens        out  current bucket level
//   stat_pkts     out  accepted packet count   (PKT_TX_PACER_STATS_EN only)
//   stat_bytes    out  accepted byte count     (PKT_TX_PACER_STATS_EN only)
//
// Build option
//   PKT_TX_PACER_STATS_EN: adds the stat_pkts/stat_bytes counters and ports.
module pkt_tx_pacer
    import pkt_tx_pacer_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned TOK_W  = TOK_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sch_valid,
    input  logic [DWIDTH-1:0]       sch_data,
    output logic                    sch_deque_en,
    input  logic                    cfg_pace_en,
    input  logic [7:0]              cfg_rate,
    input  logic [TOK_W-1:0]        cfg_burst,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [DWIDTH-LEN_W-1:0] tx_addr,
    output logic [LEN_W-1:0]        tx_len,
    output logic [TOK_W-1:0]        tokens
`ifdef PKT_TX_PACER_STATS_EN
    ,
    output logic [31:0]             stat_pkts,
    output logic [47:0]             stat_bytes
`endif
);

    localparam int unsigned CW = (TOK_W > LEN_W) ? TOK_W : LEN_W;

    pacer_state_e            state;
    logic [DWIDTH-LEN_W-1:0] addr_q;
    logic [LEN_W-1:0]        len_q;
    logic [TOK_W-1:0]        tok_nxt;
    logic                    accept;
    logic                    debit_en;
    logic                    send_ok;
    logic [CW-1:0]           len_x;
    logic [CW-1:0]           tok_nxt_x;
    logic [CW-1:0]           burst_x;

    // ------------------------------------------------------------------
    // Token bucket
    // ------------------------------------------------------------------
    assign accept   = tx_valid && tx_ready;
    // With pacing off the bucket still fills but is never charged.
    assign debit_en = accept && cfg_pace_en;

    tok_bucket #(
        .TOK_W (TOK_W),
        .LEN_W (LEN_W)
    ) u_tok_bucket (
        .clk        (clk),
        .rst        (rst),
        .rate       (cfg_rate),
        .burst      (cfg_burst),
        .debit_en   (debit_en),
        .debit_len  (len_q),
        .tokens     (tokens),
        .tokens_nxt (tok_nxt)
    );

    // ------------------------------------------------------------------
    // Send eligibility
    //   Judged on the bucket level of the next cycle (no debit can be
    //   pending while a packet waits). A packet longer than the ceiling
    //   could never be covered, so it goes once the bucket is full.
    // ------------------------------------------------------------------
    always_comb begin
        len_x     = CW'(len_q);
        tok_nxt_x = CW'(tok_nxt);
        burst_x   = CW'(cfg_burst);
        send_ok   = !cfg_pace_en
                 || (tok_nxt_x >= len_x)
                 || ((len_x > burst_x) && (tok_nxt_x == burst_x));
    end

    // Pop in the same cycle the head is seen; the FSM leaves IDLE on that
    // edge so two consecutive pops cannot happen.
    assign sch_deque_en = rst && (state == StIdle) && sch_valid;

    // ------------------------------------------------------------------
    // FSM with capture registers and registered tx_valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            tx_valid <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (sch_valid) begin
                        addr_q <= sch_data[DWIDTH-1:LEN_W];
                        len_q  <= sch_data[LEN_W-1:0];
                        state  <= StFetch;
                    end
                end
                StFetch, StWaitTok: begin
                    if (send_ok) begin
                        state    <= StSend;
                        tx_valid <= 1'b1;
                    end else begin
                        state <= StWaitTok;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        state    <= StIdle;
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Capture registers hold the descriptor steady through SEND.
    assign tx_addr = addr_q;
    assign tx_len  = len_q;

    // ------------------------------------------------------------------
    // Optional statistics (free-running, wrap at their widths)
    // ------------------------------------------------------------------
`ifdef PKT_TX_PACER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else if (accept) begin
            stat_pkts  <= stat_pkts + 32'd1;
            stat_bytes <= stat_bytes + 48'(len_q);
        end
    end
`endif

endmodule
